rs232_avalon_slave: RTL and testbench
=====================================

// Module: rs232_avalon_slave
// PURPOSE
//  Avalon-MM slave UART that the RSA wrapper master polls; it sits between the wrapper and the board RS232 pins.
//  Map: RX data @0x00, TX data @0x04, STATUS @0x08.
//  RX and TX paths are 8N1 serial engines, each buffered by its own byte FIFO.
//  Key/cipher bytes flow in from the host; decrypted bytes flow back out to it.
// PARAMETERS
//  CLKS_PER_BIT  434  avm_clk cycles per serial bit (50 MHz / 115200); must be >= 4
//  FIFO_DEPTH    4    entries per RX/TX FIFO; power of two, >= 2
// PORTS
//  avm_clk          in   1   single clock, all logic on rising edge
//  avm_rst_n        in   1   asynchronous, active-low reset
//  avs_address      in   5   byte address; only 0x00/0x04/0x08 decoded
//  avs_read         in   1   read request
//  avs_readdata     out  32  read data, registered
//  avs_write        in   1   write request
//  avs_writedata    in   32  write data, [7:0] used
//  avs_waitrequest  out  1   stall; combinational from avs_read|avs_write and ack_r
//  uart_rxd         in   1   serial in, asynchronous to avm_clk
//  uart_txd         out  1   serial out, idle high
// BEHAVIOUR
//  Reset
//   - Outputs: avs_readdata=0, uart_txd=1; ack_r=0, so avs_waitrequest=0 while idle.
//   - Internal: both FIFOs empty, all sticky flags 0, RX and TX FSMs in IDLE.
//   - Reset mid-frame aborts the frame immediately; uart_txd returns to 1.
//  Bus timing (one wait state)
//   - avs_waitrequest = (avs_read|avs_write) & !ack_r.
//   - ack_r <= (avs_read|avs_write) & !ack_r.
//   - So every transfer takes exactly 2 cycles. Cycle 1 waitrequest=1; cycle 2 waitrequest=0 (completion).
//   - In cycle 1 avs_readdata is loaded; it is valid during the completion cycle and holds until the next read.
//   - Side effects (pop, push, flag clear) happen only on the completion edge.
//   - Read and write asserted together: read wins, write is ignored.
//  Registers
//   - 0x00 read:  {24'b0, rx_fifo head}, then pop. If empty: returns 0, no pop.
//   - 0x04 write: push avs_writedata[7:0] to TX FIFO.
//       - Accepted if not full, or if the TX engine pops in the same cycle.
//       - Otherwise the byte is dropped and tx_ovf is set.
//   - 0x08 read:  bit7 RX_OK=!rx_empty, bit6 TX_OK=!tx_full, bit8 rx_ovr, bit9 tx_ovf, bit10 frm_err; others 0.
//       - Sticky bits 8..10 clear on completion, unless re-set in the same cycle (set wins).
//   - Other addresses: read 0, writes ignored, same 2-cycle timing.
//  FIFOs
//   - Circular buffers with log2(FIFO_DEPTH)-bit pointers that wrap, plus a count of width log2(FIFO_DEPTH)+1.
//   - Simultaneous push and pop: both happen, count is unchanged.
//  RX FSM (states IDLE, START, DATA, STOP)
//   - uart_rxd passes through a 2-FF synchronizer.
//   - IDLE: on synced line = 0, go to START and load the counter with CLKS_PER_BIT/2-1.
//   - START: at mid-bit, line=1 means a false start -> IDLE; line=0 -> DATA, counter reloads to CLKS_PER_BIT-1.
//   - DATA: sample 8 bits LSB-first, one per CLKS_PER_BIT, at bit centre.
//   - STOP: sample at the stop-bit centre.
//       - 1: push the byte; if the RX FIFO is full, drop it and set rx_ovr.
//       - 0: discard the byte, set frm_err, then wait for line=1 before going to IDLE.
//  TX FSM (states IDLE, START, DATA, STOP)
//   - IDLE: if the TX FIFO is non-empty, pop into a shift register and go to START.
//   - Bit periods: START drives 0 for CLKS_PER_BIT; DATA drives 8 bits LSB-first; STOP drives 1 for CLKS_PER_BIT.
//   - After STOP, back to IDLE. Back-to-back bytes have no extra idle gap.
//   - Frame length is exactly 10*CLKS_PER_BIT cycles.
// TESTING (bench uses CLKS_PER_BIT=8, FIFO_DEPTH=4)
//  1. Reset, then read 0x08 -> waitrequest high 1 cycle; completion readdata=0x40 (TX_OK only).
//  2. Serial 0xA5 on uart_rxd
//     -> STATUS bit7=1 ~80 cycles after the start edge.
//     -> read 0x00 returns 0xA5; next STATUS read = 0x40.
//  3. Write 0x3C to 0x04
//     -> uart_txd drops 1 cycle after completion.
//     -> emits 0,0,0,1,1,1,1,0,0,1, each bit held 8 cycles.
//  4. Write 6 bytes back-to-back at 0x04 while the line is busy
//     -> bytes 1-5 are sent, byte 6 is dropped.
//     -> STATUS bit9=1 and bit6=0 until a slot frees; bit9 clears after the read.
//  5. Five serial bytes with no reads -> the 5th is dropped, bit8=1; reads return bytes 1-4 in order.
//  6. Frame with stop bit 0 -> no push, bit10=1.
//     Also: a 2-cycle low glitch on uart_rxd -> no state change.
//     Also: avm_rst_n low mid-TX -> uart_txd=1 asynchronously.

Source files
------------

// File: rtl/rs232_avalon_slave.sv
// Polled Avalon-MM UART: 8N1 receive and transmit engines, each buffered by a byte FIFO.
// Map: RX data 0x00 (read pops), TX data 0x04 (write pushes), STATUS 0x08.

module rs232_byte_fifo #(
    parameter int DEPTH = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       i_push,
    input  logic [7:0] i_din,
    input  logic       i_pop,
    output logic [7:0] o_dout,
    output logic       o_empty,
    output logic       o_full
);
    localparam int PW = $clog2(DEPTH);
    localparam logic [PW-1:0] P_ZERO = PW'(0);
    localparam logic [PW-1:0] P_ONE  = PW'(1);
    localparam logic [PW:0]   C_ZERO = (PW+1)'(0);
    localparam logic [PW:0]   C_ONE  = (PW+1)'(1);
    localparam logic [PW:0]   C_FULL = (PW+1)'(DEPTH);

    logic [7:0]    r_mem [DEPTH];
    logic [PW-1:0] r_wp;
    logic [PW-1:0] r_rp;
    logic [PW:0]   r_cnt;

    assign o_dout  = r_mem[r_rp];
    assign o_empty = (r_cnt == C_ZERO);
    assign o_full  = (r_cnt == C_FULL);

    // Storage, wrapping pointers and occupancy count; push and pop together leave the count unchanged.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= 8'h00;
            end
            r_wp  <= P_ZERO;
            r_rp  <= P_ZERO;
            r_cnt <= C_ZERO;
        end else begin
            if (i_push) begin
                r_mem[r_wp] <= i_din;
                r_wp        <= r_wp + P_ONE;
            end
            if (i_pop) begin
                r_rp <= r_rp + P_ONE;
            end
            case ({i_push, i_pop})
                2'b10:   r_cnt <= r_cnt + C_ONE;
                2'b01:   r_cnt <= r_cnt - C_ONE;
                default: r_cnt <= r_cnt;
            endcase
        end
    end
endmodule

module rs232_avalon_slave #(
    parameter int CLKS_PER_BIT = 434,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic        avm_clk,
    input  logic        avm_rst_n,
    input  logic [4:0]  avs_address,
    input  logic        avs_read,
    output logic [31:0] avs_readdata,
    input  logic        avs_write,
    input  logic [31:0] avs_writedata,
    output logic        avs_waitrequest,
    input  logic        uart_rxd,
    output logic        uart_txd
);
    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] C_ZERO = CW'(0);
    localparam logic [CW-1:0] C_ONE  = CW'(1);
    localparam logic [CW-1:0] C_HALF = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] C_FULL = CW'(CLKS_PER_BIT - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } uart_state_e;

    logic        r_ack;
    logic [31:0] r_readdata;
    logic        r_rd_skip;
    logic        r_rx_ovr;
    logic        r_tx_ovf;
    logic        r_frm_err;
    logic        r_rxd_meta;
    logic        r_rxd_sync;
    logic        r_txd;

    logic        w_req;
    logic        w_done;
    logic        w_rx_pop;
    logic        w_rx_push;
    logic        w_rx_ovr_set;
    logic        w_wr_tx;
    logic        w_tx_push;
    logic        w_tx_pop;
    logic        w_tx_ovf_set;
    logic        w_stat_clr;
    logic        w_rx_empty;
    logic        w_rx_full;
    logic        w_tx_empty;
    logic        w_tx_full;
    logic [7:0]  w_rx_head;
    logic [7:0]  w_tx_head;
    logic [31:0] w_status;
    logic [31:0] w_rdata;
    logic        w_unused;

    uart_state_e r_rx_state;
    uart_state_e w_rx_state_nx;
    logic [CW-1:0] r_rx_cnt;
    logic [CW-1:0] w_rx_cnt_nx;
    logic [2:0]  r_rx_idx;
    logic [2:0]  w_rx_idx_nx;
    logic [7:0]  r_rx_shift;
    logic [7:0]  w_rx_shift_nx;
    logic        r_rx_brk;
    logic        w_rx_brk_nx;
    logic        w_rx_done;
    logic        w_frm_set;

    uart_state_e r_tx_state;
    uart_state_e w_tx_state_nx;
    logic [CW-1:0] r_tx_cnt;
    logic [CW-1:0] w_tx_cnt_nx;
    logic [2:0]  r_tx_idx;
    logic [2:0]  w_tx_idx_nx;
    logic [7:0]  r_tx_shift;
    logic [7:0]  w_tx_shift_nx;
    logic        w_txd_nx;

    assign w_unused = &{1'b0, avs_writedata[31:8]};

    // One wait state: request in cycle 1, completion (and all side effects) on the next edge.
    assign w_req           = avs_read | avs_write;
    assign avs_waitrequest = w_req & ~r_ack;
    assign w_done          = w_req & r_ack;
    assign avs_readdata    = r_readdata;
    assign uart_txd        = r_txd;

    // r_rd_skip remembers an empty RX FIFO at sample time so a byte arriving mid-transfer is not lost.
    assign w_rx_pop     = w_done & avs_read & (avs_address == 5'h00) & ~r_rd_skip;
    assign w_wr_tx      = w_done & ~avs_read & avs_write & (avs_address == 5'h04);
    assign w_tx_push    = w_wr_tx & (~w_tx_full | w_tx_pop);
    assign w_tx_ovf_set = w_wr_tx & w_tx_full & ~w_tx_pop;
    assign w_stat_clr   = w_done & avs_read & (avs_address == 5'h08);
    assign w_rx_push    = w_rx_done & ~w_rx_full;
    assign w_rx_ovr_set = w_rx_done & w_rx_full;

    assign w_status = {21'd0, r_frm_err, r_tx_ovf, r_rx_ovr, ~w_rx_empty, ~w_tx_full, 6'd0};

    rs232_byte_fifo #(.DEPTH(FIFO_DEPTH)) u_rx_fifo (
        .clk     (avm_clk),
        .rst_n   (avm_rst_n),
        .i_push  (w_rx_push),
        .i_din   (r_rx_shift),
        .i_pop   (w_rx_pop),
        .o_dout  (w_rx_head),
        .o_empty (w_rx_empty),
        .o_full  (w_rx_full)
    );

    rs232_byte_fifo #(.DEPTH(FIFO_DEPTH)) u_tx_fifo (
        .clk     (avm_clk),
        .rst_n   (avm_rst_n),
        .i_push  (w_tx_push),
        .i_din   (avs_writedata[7:0]),
        .i_pop   (w_tx_pop),
        .o_dout  (w_tx_head),
        .o_empty (w_tx_empty),
        .o_full  (w_tx_full)
    );

    // Read-data source for the addressed register.
    always_comb begin
        w_rdata = 32'h0000_0000;
        case (avs_address)
            5'h00:   w_rdata = {24'h00_0000, (w_rx_empty ? 8'h00 : w_rx_head)};
            5'h08:   w_rdata = w_status;
            default: w_rdata = 32'h0000_0000;
        endcase
    end

    // Bus handshake and registered read data, captured in the first cycle of a read.
    always_ff @(posedge avm_clk or negedge avm_rst_n) begin
        if (!avm_rst_n) begin
            r_ack      <= 1'b0;
            r_readdata <= 32'h0000_0000;
            r_rd_skip  <= 1'b0;
        end else begin
            r_ack <= w_req & ~r_ack;
            if (avs_read & ~r_ack) begin
                r_readdata <= w_rdata;
                r_rd_skip  <= w_rx_empty;
            end else begin
                r_readdata <= r_readdata;
                r_rd_skip  <= r_rd_skip;
            end
        end
    end

    // Sticky error flags: a set in the same cycle as the clearing read wins.
    always_ff @(posedge avm_clk or negedge avm_rst_n) begin
        if (!avm_rst_n) begin
            r_rx_ovr  <= 1'b0;
            r_tx_ovf  <= 1'b0;
            r_frm_err <= 1'b0;
        end else begin
            r_rx_ovr  <= w_rx_ovr_set | (r_rx_ovr  & ~w_stat_clr);
            r_tx_ovf  <= w_tx_ovf_set | (r_tx_ovf  & ~w_stat_clr);
            r_frm_err <= w_frm_set    | (r_frm_err & ~w_stat_clr);
        end
    end

    // Two-flop synchronizer for the asynchronous serial input; idles high.
    always_ff @(posedge avm_clk or negedge avm_rst_n) begin
        if (!avm_rst_n) begin
            r_rxd_meta <= 1'b1;
            r_rxd_sync <= 1'b1;
        end else begin
            r_rxd_meta <= uart_rxd;
            r_rxd_sync <= r_rxd_meta;
        end
    end

    // RX next state: half-bit wait validates the start bit, later samples land at bit centres.
    always_comb begin
        w_rx_state_nx = r_rx_state;
        w_rx_cnt_nx   = r_rx_cnt;
        w_rx_idx_nx   = r_rx_idx;
        w_rx_shift_nx = r_rx_shift;
        w_rx_brk_nx   = r_rx_brk;
        w_rx_done     = 1'b0;
        w_frm_set     = 1'b0;
        case (r_rx_state)
            ST_IDLE: begin
                if (!r_rxd_sync) begin
                    w_rx_state_nx = ST_START;
                    w_rx_cnt_nx   = C_HALF;
                end else begin
                    w_rx_state_nx = ST_IDLE;
                end
            end
            ST_START: begin
                if (r_rx_cnt != C_ZERO) begin
                    w_rx_cnt_nx = r_rx_cnt - C_ONE;
                end else if (r_rxd_sync) begin
                    w_rx_state_nx = ST_IDLE;
                end else begin
                    w_rx_state_nx = ST_DATA;
                    w_rx_cnt_nx   = C_FULL;
                    w_rx_idx_nx   = 3'd0;
                end
            end
            ST_DATA: begin
                if (r_rx_cnt != C_ZERO) begin
                    w_rx_cnt_nx = r_rx_cnt - C_ONE;
                end else begin
                    w_rx_shift_nx = {r_rxd_sync, r_rx_shift[7:1]};
                    w_rx_cnt_nx   = C_FULL;
                    if (r_rx_idx == 3'd7) begin
                        w_rx_state_nx = ST_STOP;
                    end else begin
                        w_rx_idx_nx = r_rx_idx + 3'd1;
                    end
                end
            end
            ST_STOP: begin
                if (r_rx_brk) begin
                    if (r_rxd_sync) begin
                        w_rx_state_nx = ST_IDLE;
                        w_rx_brk_nx   = 1'b0;
                    end else begin
                        w_rx_brk_nx = 1'b1;
                    end
                end else if (r_rx_cnt != C_ZERO) begin
                    w_rx_cnt_nx = r_rx_cnt - C_ONE;
                end else if (r_rxd_sync) begin
                    w_rx_done     = 1'b1;
                    w_rx_state_nx = ST_IDLE;
                end else begin
                    w_frm_set   = 1'b1;
                    w_rx_brk_nx = 1'b1;
                end
            end
            default: begin
                w_rx_state_nx = ST_IDLE;
                w_rx_brk_nx   = 1'b0;
            end
        endcase
    end

    // RX state register.
    always_ff @(posedge avm_clk or negedge avm_rst_n) begin
        if (!avm_rst_n) begin
            r_rx_state <= ST_IDLE;
            r_rx_cnt   <= C_ZERO;
            r_rx_idx   <= 3'd0;
            r_rx_shift <= 8'h00;
            r_rx_brk   <= 1'b0;
        end else begin
            r_rx_state <= w_rx_state_nx;
            r_rx_cnt   <= w_rx_cnt_nx;
            r_rx_idx   <= w_rx_idx_nx;
            r_rx_shift <= w_rx_shift_nx;
            r_rx_brk   <= w_rx_brk_nx;
        end
    end

    // TX next state: the end of a stop bit chains straight into the next queued byte.
    always_comb begin
        w_tx_state_nx = r_tx_state;
        w_tx_cnt_nx   = r_tx_cnt;
        w_tx_idx_nx   = r_tx_idx;
        w_tx_shift_nx = r_tx_shift;
        w_txd_nx      = r_txd;
        w_tx_pop      = 1'b0;
        case (r_tx_state)
            ST_IDLE: begin
                w_txd_nx = 1'b1;
                if (!w_tx_empty) begin
                    w_tx_pop      = 1'b1;
                    w_tx_shift_nx = w_tx_head;
                    w_tx_cnt_nx   = C_FULL;
                    w_tx_state_nx = ST_START;
                    w_txd_nx      = 1'b0;
                end else begin
                    w_tx_state_nx = ST_IDLE;
                end
            end
            ST_START: begin
                if (r_tx_cnt != C_ZERO) begin
                    w_tx_cnt_nx = r_tx_cnt - C_ONE;
                end else begin
                    w_tx_cnt_nx   = C_FULL;
                    w_tx_idx_nx   = 3'd0;
                    w_tx_state_nx = ST_DATA;
                    w_txd_nx      = r_tx_shift[0];
                end
            end
            ST_DATA: begin
                if (r_tx_cnt != C_ZERO) begin
                    w_tx_cnt_nx = r_tx_cnt - C_ONE;
                end else begin
                    w_tx_cnt_nx = C_FULL;
                    if (r_tx_idx == 3'd7) begin
                        w_tx_state_nx = ST_STOP;
                        w_txd_nx      = 1'b1;
                    end else begin
                        w_tx_idx_nx   = r_tx_idx + 3'd1;
                        w_tx_shift_nx = {1'b0, r_tx_shift[7:1]};
                        w_txd_nx      = r_tx_shift[1];
                    end
                end
            end
            ST_STOP: begin
                if (r_tx_cnt != C_ZERO) begin
                    w_tx_cnt_nx = r_tx_cnt - C_ONE;
                end else if (!w_tx_empty) begin
                    w_tx_pop      = 1'b1;
                    w_tx_shift_nx = w_tx_head;
                    w_tx_cnt_nx   = C_FULL;
                    w_tx_state_nx = ST_START;
                    w_txd_nx      = 1'b0;
                end else begin
                    w_tx_state_nx = ST_IDLE;
                    w_txd_nx      = 1'b1;
                end
            end
            default: begin
                w_tx_state_nx = ST_IDLE;
                w_txd_nx      = 1'b1;
            end
        endcase
    end

    // TX state register; the serial output is registered and forced idle-high by reset.
    always_ff @(posedge avm_clk or negedge avm_rst_n) begin
        if (!avm_rst_n) begin
            r_tx_state <= ST_IDLE;
            r_tx_cnt   <= C_ZERO;
            r_tx_idx   <= 3'd0;
            r_tx_shift <= 8'h00;
            r_txd      <= 1'b1;
        end else begin
            r_tx_state <= w_tx_state_nx;
            r_tx_cnt   <= w_tx_cnt_nx;
            r_tx_idx   <= w_tx_idx_nx;
            r_tx_shift <= w_tx_shift_nx;
            r_txd      <= w_txd_nx;
        end
    end
endmodule

// File: tb/tb_rs232_avalon_slave.sv
// Directed bench for rs232_avalon_slave: register-map table plus serial RX/TX, overflow,
// framing-error, glitch and mid-frame reset sequences with hand-computed expectations.

module tb_rs232_avalon_slave;
    localparam int CPB   = 8;
    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [4:0]  avs_address;
    logic        avs_read;
    logic [31:0] avs_readdata;
    logic        avs_write;
    logic [31:0] avs_writedata;
    logic        avs_waitrequest;
    logic        uart_rxd;
    logic        uart_txd;

    int n_cmp  = 0;
    int n_fail = 0;

    typedef struct {
        logic        rd;
        logic [4:0]  addr;
        logic [31:0] wdata;
        logic [31:0] exp;
        string       name;
    } vec_t;

    vec_t vt [8];

    rs232_avalon_slave #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH)) dut (
        .avm_clk         (clk),
        .avm_rst_n       (rst_n),
        .avs_address     (avs_address),
        .avs_read        (avs_read),
        .avs_readdata    (avs_readdata),
        .avs_write       (avs_write),
        .avs_writedata   (avs_writedata),
        .avs_waitrequest (avs_waitrequest),
        .uart_rxd        (uart_rxd),
        .uart_txd        (uart_txd)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic bus_read(input logic [4:0] a, input logic [31:0] exp, input string name);
        @(posedge clk); #1;
        avs_address = a;
        avs_read    = 1'b1;
        @(negedge clk);
        check({name, "/wait1"}, 32'(avs_waitrequest), 32'd1);
        @(posedge clk); #1;
        check({name, "/wait2"}, 32'(avs_waitrequest), 32'd0);
        check(name, avs_readdata, exp);
        @(posedge clk); #1;
        avs_read = 1'b0;
    endtask

    task automatic bus_write(input logic [4:0] a, input logic [31:0] d, input string name);
        @(posedge clk); #1;
        avs_address   = a;
        avs_writedata = d;
        avs_write     = 1'b1;
        @(negedge clk);
        check({name, "/wait1"}, 32'(avs_waitrequest), 32'd1);
        @(posedge clk); #1;
        check({name, "/wait2"}, 32'(avs_waitrequest), 32'd0);
        @(posedge clk); #1;
        avs_write = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop);
        logic [9:0] fr;
        fr = {stop, b, 1'b0};
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            uart_rxd = fr[i];
            repeat (CPB - 1) @(posedge clk);
        end
        @(posedge clk); #1;
        uart_rxd = 1'b1;
    endtask

    // Receives one frame from uart_txd, sampling each bit at its centre.
    task automatic rx_frame(output logic [7:0] b, output logic ok);
        logic found;
        logic st;
        logic sp;
        found = 1'b0;
        b     = 8'h00;
        ok    = 1'b0;
        for (int t = 0; t < 400 && !found; t++) begin
            @(posedge clk); #1;
            if (uart_txd == 1'b0) found = 1'b1;
        end
        if (found) begin
            repeat (CPB / 2) @(posedge clk);
            #1 st = uart_txd;
            for (int j = 0; j < 8; j++) begin
                repeat (CPB) @(posedge clk);
                #1 b[j] = uart_txd;
            end
            repeat (CPB) @(posedge clk);
            #1 sp = uart_txd;
            ok = (st == 1'b0) && (sp == 1'b1);
        end
    endtask

    task automatic count_txd_low(input int cycles, output int lows);
        lows = 0;
        for (int i = 0; i < cycles; i++) begin
            @(posedge clk); #1;
            if (uart_txd == 1'b0) lows++;
        end
    endtask

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation time limit reached");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [9:0]  fr3;
        logic [7:0]  tx_bytes [6];
        logic [7:0]  got [5];
        logic        got_ok [5];
        logic [7:0]  rx_bytes [5];
        int          lows;

        vt[0] = '{1'b1, 5'h08, 32'h0,  32'h0000_0040, "t1_status_reset"};
        vt[1] = '{1'b1, 5'h00, 32'h0,  32'h0000_0000, "rx_empty_read"};
        vt[2] = '{1'b1, 5'h04, 32'h0,  32'h0000_0000, "tx_addr_read"};
        vt[3] = '{1'b1, 5'h0C, 32'h0,  32'h0000_0000, "unmapped_0c"};
        vt[4] = '{1'b0, 5'h00, 32'h77, 32'h0000_0000, "write_rx_addr"};
        vt[5] = '{1'b0, 5'h10, 32'h66, 32'h0000_0000, "write_unmapped"};
        vt[6] = '{1'b1, 5'h1C, 32'h0,  32'h0000_0000, "unmapped_1c"};
        vt[7] = '{1'b1, 5'h08, 32'h0,  32'h0000_0040, "status_after_table"};

        rst_n         = 1'b0;
        avs_address   = 5'h00;
        avs_read      = 1'b0;
        avs_write     = 1'b0;
        avs_writedata = 32'h0;
        uart_rxd      = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("reset_readdata", avs_readdata, 32'h0);
        check("reset_txd", 32'(uart_txd), 32'd1);
        check("reset_wait", 32'(avs_waitrequest), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 8; i++) begin
            if (vt[i].rd) bus_read(vt[i].addr, vt[i].exp, vt[i].name);
            else          bus_write(vt[i].addr, vt[i].wdata, vt[i].name);
        end

        // Read and write together at the TX address: read wins, nothing is queued.
        @(posedge clk); #1;
        avs_address = 5'h04; avs_writedata = 32'h55; avs_read = 1'b1; avs_write = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        avs_read = 1'b0; avs_write = 1'b0;
        count_txd_low(30, lows);
        check("rw_together_no_tx", 32'(lows), 32'd0);

        // Serial receive of 0xA5.
        fork
            send_byte(8'hA5, 1'b1);
            begin
                repeat (60) @(posedge clk);
                bus_read(5'h08, 32'h40, "t2_status_midframe");
            end
        join
        bus_read(5'h08, 32'hC0, "t2_status_rx_ok");
        bus_read(5'h00, 32'hA5, "t2_rx_data");
        bus_read(5'h08, 32'h40, "t2_status_after");

        // Transmit 0x3C, checked cycle by cycle.
        fr3 = {1'b1, 8'h3C, 1'b0};
        bus_write(5'h04, 32'hFFFF_FF3C, "t3_write");
        check("t3_idle_at_completion", 32'(uart_txd), 32'd1);
        for (int k = 0; k < 10 * CPB; k++) begin
            @(posedge clk); #1;
            check($sformatf("t3_bit%0d_cyc%0d", k / CPB, k % CPB), 32'(uart_txd), 32'(fr3[k / CPB]));
        end
        @(posedge clk); #1;
        check("t3_idle_after", 32'(uart_txd), 32'd1);

        // Six back-to-back writes: first goes to the engine, four fill the FIFO, sixth dropped.
        tx_bytes[0] = 8'h81; tx_bytes[1] = 8'h42; tx_bytes[2] = 8'h24;
        tx_bytes[3] = 8'h18; tx_bytes[4] = 8'hE7; tx_bytes[5] = 8'h99;
        fork
            begin
                for (int i = 0; i < 5; i++) rx_frame(got[i], got_ok[i]);
            end
            begin
                for (int i = 0; i < 6; i++) bus_write(5'h04, {24'h0, tx_bytes[i]}, $sformatf("t4_write%0d", i));
                bus_read(5'h08, 32'h200, "t4_status_ovf_full");
                bus_read(5'h08, 32'h000, "t4_status_cleared_full");
            end
        join
        for (int i = 0; i < 5; i++) begin
            check($sformatf("t4_frame%0d_ok", i), 32'(got_ok[i]), 32'd1);
            check($sformatf("t4_frame%0d_byte", i), 32'(got[i]), 32'(tx_bytes[i]));
        end
        count_txd_low(120, lows);
        check("t4_no_sixth_frame", 32'(lows), 32'd0);
        bus_read(5'h08, 32'h40, "t4_status_idle");

        // Five received bytes with no reads: fifth overflows.
        rx_bytes[0] = 8'h11; rx_bytes[1] = 8'h22; rx_bytes[2] = 8'h33;
        rx_bytes[3] = 8'h44; rx_bytes[4] = 8'h55;
        for (int i = 0; i < 5; i++) send_byte(rx_bytes[i], 1'b1);
        repeat (4) @(posedge clk);
        bus_read(5'h08, 32'h1C0, "t5_status_ovr");
        for (int i = 0; i < 4; i++) bus_read(5'h00, 32'(rx_bytes[i]), $sformatf("t5_rx%0d", i));
        bus_read(5'h08, 32'h40, "t5_status_after");
        bus_read(5'h00, 32'h0, "t5_rx_empty");

        // Framing error: stop bit low.
        send_byte(8'h5A, 1'b0);
        repeat (10) @(posedge clk);
        bus_read(5'h08, 32'h440, "t6_status_frm");
        bus_read(5'h08, 32'h40, "t6_status_frm_clr");
        bus_read(5'h00, 32'h0, "t6_no_push");

        // Two-cycle low glitch, then a good byte to show the receiver is not stuck.
        @(posedge clk); #1;
        uart_rxd = 1'b0;
        repeat (2) @(posedge clk);
        #1 uart_rxd = 1'b1;
        repeat (100) @(posedge clk);
        bus_read(5'h08, 32'h40, "t6_glitch_status");
        send_byte(8'h96, 1'b1);
        repeat (4) @(posedge clk);
        bus_read(5'h00, 32'h96, "t6_rx_after_glitch");

        // Reset in the middle of a transmitted frame.
        bus_read(5'h08, 32'h40, "t6_pre_reset_status");
        bus_write(5'h04, 32'h0, "t6_write_zero");
        repeat (20) @(posedge clk);
        #1;
        check("t6_txd_low_midframe", 32'(uart_txd), 32'd0);
        #3 rst_n = 1'b0;
        #1;
        check("t6_txd_async_reset", 32'(uart_txd), 32'd1);
        check("t6_readdata_reset", avs_readdata, 32'h0);
        check("t6_wait_reset", 32'(avs_waitrequest), 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        count_txd_low(120, lows);
        check("t6_frame_aborted", 32'(lows), 32'd0);
        bus_read(5'h08, 32'h40, "t6_status_post_reset");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
